branch_predictor: RTL and testbench

- Fetch-stage direct-mapped branch target buffer with per-entry saturating direction counters. It generalises the branch request/feedback signalling into a parametrised predictor.
- Fetch looks up the current PC combinationally and gets a predicted next PC.
- Execute returns resolved branch/jump feedback. The block updates the table, raises a same-cycle redirect on mispredict, and keeps saturating branch and mispredict statistics.

---
 rtl/branch_predictor_if.sv | 62 ++++++
 rtl/branch_predictor.sv | 105 ++++++++++
 tb/tb_branch_predictor.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/branch_predictor_if.sv
// Fetch/execute side signals of the branch predictor.
// master: pipeline (drives fetch_pc and feedback); slave: predictor.
`ifndef PC_SIZE
`define PC_SIZE 16
`endif

interface branch_predictor_if #(
    parameter int PC_W   = `PC_SIZE,
    parameter int STAT_W = 16
);
    logic              fetch_pc_unused_guard;
    logic [PC_W-1:0]   fetch_pc;
    logic              predict_taken;
    logic [PC_W-1:0]   predict_target;
    logic              fb_branch;
    logic              fb_jump;
    logic [PC_W-1:0]   fb_pc;
    logic              fb_predict_taken;
    logic [PC_W-1:0]   fb_predict_target;
    logic              fb_feedback_taken;
    logic [PC_W-1:0]   fb_feedback_target;
    logic              redirect;
    logic [PC_W-1:0]   redirect_pc;
    logic [STAT_W-1:0] stat_branches;
    logic [STAT_W-1:0] stat_mispredicts;

    assign fetch_pc_unused_guard = 1'b0;

    modport master (
        output fetch_pc,
        input  predict_taken,
        input  predict_target,
        output fb_branch,
        output fb_jump,
        output fb_pc,
        output fb_predict_taken,
        output fb_predict_target,
        output fb_feedback_taken,
        output fb_feedback_target,
        input  redirect,
        input  redirect_pc,
        input  stat_branches,
        input  stat_mispredicts
    );

    modport slave (
        input  fetch_pc,
        output predict_taken,
        output predict_target,
        input  fb_branch,
        input  fb_jump,
        input  fb_pc,
        input  fb_predict_taken,
        input  fb_predict_target,
        input  fb_feedback_taken,
        input  fb_feedback_target,
        output redirect,
        output redirect_pc,
        output stat_branches,
        output stat_mispredicts
    );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with saturating direction counters and statistics.
// Ports: clk, rst (sync, active-high), bp (branch_predictor_if.slave).
`ifndef PC_SIZE
`define PC_SIZE 16
`endif

module branch_predictor #(
    parameter int PC_W    = `PC_SIZE,
    parameter int ENTRIES = 16,
    parameter int CTR_W   = 2,
    parameter int STAT_W  = 16
) (
    input logic              clk,
    input logic              rst,
    branch_predictor_if.slave bp
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = PC_W - IDX_W;
    localparam logic [CTR_W-1:0]  CTR_MAX  = '1;
    localparam logic [CTR_W-1:0]  CTR_WEAK = CTR_W'(1) << (CTR_W - 1);
    localparam logic [STAT_W-1:0] STAT_MAX = '1;

    logic             valid   [ENTRIES];
    logic             is_jump [ENTRIES];
    logic [TAG_W-1:0] tag     [ENTRIES];
    logic [PC_W-1:0]  target  [ENTRIES];
    logic [CTR_W-1:0] ctr     [ENTRIES];

    logic [STAT_W-1:0] stat_br;
    logic [STAT_W-1:0] stat_mp;

    // lookup
    logic [IDX_W-1:0] l_idx;
    logic [TAG_W-1:0] l_tag;
    logic             l_hit;

    assign l_idx = bp.fetch_pc[IDX_W-1:0];
    assign l_tag = bp.fetch_pc[PC_W-1:IDX_W];
    assign l_hit = valid[l_idx] && (tag[l_idx] == l_tag);

    assign bp.predict_taken  = l_hit && (is_jump[l_idx] || ctr[l_idx][CTR_W-1]);
    assign bp.predict_target = bp.predict_taken ? target[l_idx]
                                                : bp.fetch_pc + PC_W'(1);

    // feedback
    logic [IDX_W-1:0] f_idx;
    logic [TAG_W-1:0] f_tag;
    logic             f_hit;
    logic             fb_valid;
    logic             mispredict;

    assign f_idx    = bp.fb_pc[IDX_W-1:0];
    assign f_tag    = bp.fb_pc[PC_W-1:IDX_W];
    assign f_hit    = valid[f_idx] && (tag[f_idx] == f_tag);
    assign fb_valid = bp.fb_branch | bp.fb_jump;

    assign mispredict = fb_valid &&
        ((bp.fb_predict_taken != bp.fb_feedback_taken) ||
         (bp.fb_feedback_taken &&
          (bp.fb_predict_target != bp.fb_feedback_target)));

    assign bp.redirect    = mispredict;
    assign bp.redirect_pc = !mispredict          ? '0 :
                            bp.fb_feedback_taken ? bp.fb_feedback_target :
                                                   bp.fb_pc + PC_W'(1);

    assign bp.stat_branches    = stat_br;
    assign bp.stat_mispredicts = stat_mp;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid[i]   <= 1'b0;
                is_jump[i] <= 1'b0;
                ctr[i]     <= '0;
            end
            stat_br <= '0;
            stat_mp <= '0;
        end else if (fb_valid) begin
            if (stat_br != STAT_MAX) stat_br <= stat_br + STAT_W'(1);
            if (mispredict && stat_mp != STAT_MAX)
                stat_mp <= stat_mp + STAT_W'(1);

            if (f_hit) begin
                // fb_jump wins when both strobes are high
                if (bp.fb_jump) begin
                    target[f_idx] <= bp.fb_feedback_target;
                    ctr[f_idx]    <= CTR_MAX;
                end else if (bp.fb_feedback_taken) begin
                    target[f_idx] <= bp.fb_feedback_target;
                    if (ctr[f_idx] != CTR_MAX)
                        ctr[f_idx] <= ctr[f_idx] + CTR_W'(1);
                end else if (ctr[f_idx] != '0) begin
                    ctr[f_idx] <= ctr[f_idx] - CTR_W'(1);
                end
            end else if (bp.fb_feedback_taken) begin
                valid[f_idx]   <= 1'b1;
                is_jump[f_idx] <= bp.fb_jump;
                tag[f_idx]     <= f_tag;
                target[f_idx]  <= bp.fb_feedback_target;
                ctr[f_idx]     <= bp.fb_jump ? CTR_MAX : CTR_WEAK;
            end
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// Directed table-driven bench for branch_predictor.
// PC_W=16, ENTRIES=16, CTR_W=2, STAT_W=4.
module tb_branch_predictor;
    logic clk;
    logic rst;

    branch_predictor_if #(.PC_W(16), .STAT_W(4)) bp ();

    branch_predictor #(
        .PC_W(16), .ENTRIES(16), .CTR_W(2), .STAT_W(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bp (bp.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        chk;
        logic [15:0] fetch;
        logic        br;
        logic        jp;
        logic [15:0] fpc;
        logic        pt;
        logic [15:0] ptgt;
        logic        ft;
        logic [15:0] ftgt;
        logic        e_tk;
        logic [15:0] e_tgt;
        logic        e_rd;
        logic [15:0] e_rpc;
        logic [3:0]  e_sb;
        logic [3:0]  e_sm;
    } vec_t;

    vec_t tab_a[$];
    vec_t tab_b[$];
    int   total = 0;
    int   bad   = 0;

    function automatic vec_t mk(
        input logic r, input logic c, input logic [15:0] f,
        input logic b, input logic j, input logic [15:0] p,
        input logic pt, input logic [15:0] ptg,
        input logic ft, input logic [15:0] ftg,
        input logic tk, input logic [15:0] tg,
        input logic rd, input logic [15:0] rpc,
        input logic [3:0] sb, input logic [3:0] sm);
        vec_t v;
        v.rst = r;  v.chk = c;  v.fetch = f;
        v.br = b;   v.jp = j;   v.fpc = p;
        v.pt = pt;  v.ptgt = ptg;
        v.ft = ft;  v.ftgt = ftg;
        v.e_tk = tk; v.e_tgt = tg;
        v.e_rd = rd; v.e_rpc = rpc;
        v.e_sb = sb; v.e_sm = sm;
        return v;
    endfunction

    function automatic vec_t idle(input logic [15:0] f,
        input logic tk, input logic [15:0] tg,
        input logic [3:0] sb, input logic [3:0] sm);
        return mk(0, 1, f, 0, 0, 16'h0, 0, 16'h0, 0, 16'h0,
                  tk, tg, 0, 16'h0, sb, sm);
    endfunction

    task automatic chk1(input string nm, input logic [15:0] act,
                        input logic [15:0] exp, input int n);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s vec=%0d got=%h want=%h", nm, n, act, exp);
        end
    endtask

    task automatic run(input vec_t v, input int n);
        @(negedge clk);
        rst                   = v.rst;
        bp.fetch_pc           = v.fetch;
        bp.fb_branch          = v.br;
        bp.fb_jump            = v.jp;
        bp.fb_pc              = v.fpc;
        bp.fb_predict_taken   = v.pt;
        bp.fb_predict_target  = v.ptgt;
        bp.fb_feedback_taken  = v.ft;
        bp.fb_feedback_target = v.ftgt;
        #1;
        if (v.chk) begin
            chk1("predict_taken", 16'(bp.predict_taken), 16'(v.e_tk), n);
            chk1("predict_target", bp.predict_target, v.e_tgt, n);
            chk1("redirect", 16'(bp.redirect), 16'(v.e_rd), n);
            chk1("redirect_pc", bp.redirect_pc, v.e_rpc, n);
        end
        @(posedge clk);
        #1;
        chk1("stat_branches", 16'(bp.stat_branches), 16'(v.e_sb), n);
        chk1("stat_mispredicts", 16'(bp.stat_mispredicts), 16'(v.e_sm), n);
    endtask

    initial begin
        // reset, lookup defaults, wrap
        tab_a.push_back(mk(1, 0, 16'h0005, 0, 0, 0, 0, 0, 0, 0,
                           0, 0, 0, 0, 0, 0));
        tab_a.push_back(idle(16'h0005, 0, 16'h0006, 0, 0));
        tab_a.push_back(idle(16'hFFFF, 0, 16'h0000, 0, 0));
        // taken miss allocates, weakly taken
        tab_a.push_back(mk(0, 1, 16'h0005, 1, 0, 16'h0005, 0, 16'h0, 1, 16'h0040,
                           0, 16'h0006, 1, 16'h0040, 1, 1));
        tab_a.push_back(idle(16'h0005, 1, 16'h0040, 1, 1));
        // not-taken steps ctr down; saturates at 0
        tab_a.push_back(mk(0, 1, 16'h0005, 1, 0, 16'h0005, 1, 16'h0040, 0, 16'h0,
                           1, 16'h0040, 1, 16'h0006, 2, 2));
        tab_a.push_back(idle(16'h0005, 0, 16'h0006, 2, 2));
        tab_a.push_back(mk(0, 1, 16'h0005, 1, 0, 16'h0005, 0, 16'h0, 0, 16'h0,
                           0, 16'h0006, 0, 16'h0, 3, 2));
        tab_a.push_back(mk(0, 1, 16'h0005, 1, 0, 16'h0005, 0, 16'h0, 0, 16'h0,
                           0, 16'h0006, 0, 16'h0, 4, 2));
        tab_a.push_back(mk(0, 1, 16'h0005, 1, 0, 16'h0005, 0, 16'h0, 1, 16'h0040,
                           0, 16'h0006, 1, 16'h0040, 5, 3));
        tab_a.push_back(idle(16'h0005, 0, 16'h0006, 5, 3));
        // alias replaces index 5
        tab_a.push_back(mk(0, 1, 16'h0015, 1, 0, 16'h0015, 0, 16'h0, 1, 16'h0080,
                           0, 16'h0016, 1, 16'h0080, 6, 4));
        tab_a.push_back(idle(16'h0005, 0, 16'h0006, 6, 4));
        tab_a.push_back(idle(16'h0015, 1, 16'h0080, 6, 4));
        // not-taken miss: no allocation
        tab_a.push_back(mk(0, 1, 16'h0027, 1, 0, 16'h0027, 0, 16'h0, 0, 16'h0,
                           0, 16'h0028, 0, 16'h0, 7, 4));
        tab_a.push_back(idle(16'h0027, 0, 16'h0028, 7, 4));
        // jump; same-cycle lookup sees old miss
        tab_a.push_back(mk(0, 1, 16'h0020, 0, 1, 16'h0020, 0, 16'h0, 1, 16'h0100,
                           0, 16'h0021, 1, 16'h0100, 8, 5));
        for (int i = 0; i < 3; i++)
            tab_a.push_back(mk(0, 1, 16'h0020, 1, 0, 16'h0020, 1, 16'h0100,
                               0, 16'h0, 1, 16'h0100, 1, 16'h0021,
                               4'(9 + i), 4'(6 + i)));
        tab_a.push_back(idle(16'h0020, 1, 16'h0100, 11, 8));
        // branch+jump together acts as jump
        tab_a.push_back(mk(0, 1, 16'h0031, 1, 1, 16'h0031, 1, 16'h0200, 1, 16'h0200,
                           0, 16'h0032, 0, 16'h0, 12, 8));
        tab_a.push_back(idle(16'h0031, 1, 16'h0200, 12, 8));
        tab_a.push_back(mk(0, 1, 16'h0031, 1, 0, 16'h0031, 1, 16'h0200, 0, 16'h0,
                           1, 16'h0200, 1, 16'h0032, 13, 9));
        tab_a.push_back(idle(16'h0031, 1, 16'h0200, 13, 9));
        // target-only mispredict retargets entry
        tab_a.push_back(mk(0, 1, 16'h0015, 1, 0, 16'h0015, 1, 16'h0080, 1, 16'h0090,
                           1, 16'h0080, 1, 16'h0090, 14, 10));
        tab_a.push_back(idle(16'h0015, 1, 16'h0090, 14, 10));

        // reset with feedback in the same cycle
        tab_b.push_back(mk(1, 1, 16'h0003, 1, 0, 16'h0009, 0, 16'h0, 1, 16'h0050,
                           1, 16'h0010, 1, 16'h0050, 0, 0));
        tab_b.push_back(idle(16'h0009, 0, 16'h000A, 0, 0));
        tab_b.push_back(idle(16'h0020, 0, 16'h0021, 0, 0));
        tab_b.push_back(idle(16'h0003, 0, 16'h0004, 0, 0));
        tab_b.push_back(idle(16'h0015, 0, 16'h0016, 0, 0));
        tab_b.push_back(idle(16'h0031, 0, 16'h0032, 0, 0));

        rst = 1'b1;
        bp.fetch_pc = '0;
        bp.fb_branch = 0;
        bp.fb_jump = 0;
        bp.fb_pc = '0;
        bp.fb_predict_taken = 0;
        bp.fb_predict_target = '0;
        bp.fb_feedback_taken = 0;
        bp.fb_feedback_target = '0;

        foreach (tab_a[i]) run(tab_a[i], i);

        // 20 consecutive mispredicts saturate both stats
        for (int i = 0; i < 20; i++) begin
            int sb, sm;
            vec_t v;
            sb = (14 + i + 1 > 15) ? 15 : 14 + i + 1;
            sm = (10 + i + 1 > 15) ? 15 : 10 + i + 1;
            v = mk(0, 1, 16'h0003, 1, 0, 16'h0003, 0, 16'h0, 1, 16'h0010,
                   (i > 0), (i > 0) ? 16'h0010 : 16'h0004,
                   1, 16'h0010, 4'(sb), 4'(sm));
            run(v, 100 + i);
        end

        foreach (tab_b[i]) run(tab_b[i], 200 + i);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
